// File: rtl/ntt_core_intt_final_twd_mult.sv
// Final INTT scaling: each coefficient is multiplied by its twiddle mod MOD_NTT.
// One twiddle set serves GLWE_K_P1 polynomials and is released by a ready pulse.

module ntt_core_intt_final_twd_mult_lane #(
   parameter int              OP_W    = 32,
   parameter logic [OP_W-1:0] MOD_NTT = '1
) (
   input  logic            clk,
   input  logic            s_rst_n,
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   output logic [OP_W-1:0] z
);
   localparam int PW = 2*OP_W;

   logic [PW-1:0] prod;

   // Full-width product first, reduction in the second stage.
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         prod <= '0;
         z    <= '0;
      end else begin
         prod <= PW'(a) * PW'(b);
         z    <= OP_W'(prod % PW'(MOD_NTT));
      end
   end
endmodule

module ntt_core_intt_final_twd_mult #(
   parameter int              OP_W      = 32,
   parameter logic [OP_W-1:0] MOD_NTT   = OP_W'(64'd4294967296 - 64'd131072 + 64'd1),
   parameter int              R         = 8,
   parameter int              PSI       = 8,
   parameter int              S         = 3,
   parameter int              GLWE_K_P1 = 2,
   localparam int             STG_ITER_NB = (R**S)/(R*PSI),
   localparam int             SI_W = (STG_ITER_NB > 1) ? $clog2(STG_ITER_NB) : 1,
   localparam int             ID_W = (GLWE_K_P1 > 1) ? $clog2(GLWE_K_P1) : 1
) (
   input  logic                          clk,
   input  logic                          s_rst_n,
   input  logic [PSI-1:0][R-1:0][OP_W-1:0] in_data,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic [PSI-1:0][R-1:0][OP_W-1:0] twd_intt_final,
   input  logic [PSI-1:0][R-1:0]         twd_intt_final_vld,
   output logic [PSI-1:0][R-1:0]         twd_intt_final_rdy,
   output logic [PSI-1:0][R-1:0][OP_W-1:0] out_data,
   output logic                          out_vld,
   output logic [SI_W-1:0]               out_stg_iter,
   output logic [ID_W-1:0]               out_intt_id,
   output logic                          error
);
   localparam int              NL      = PSI*R;
   localparam int              STAGES  = 2;
   localparam logic [ID_W-1:0] ID_MAX  = ID_W'(GLWE_K_P1-1);
   localparam logic [SI_W-1:0] SI_MAX  = SI_W'(STG_ITER_NB-1);
   localparam logic [4:0]      STV_MAX = 5'd16;

   typedef struct packed {
      logic [SI_W-1:0] stg_iter;
      logic [ID_W-1:0] intt_id;
   } meta_t;

   logic               vld_all, vld_any, twd_ok, acc, last_id, primed, err_nxt;
   logic [ID_W-1:0]    intt_cnt;
   logic [SI_W-1:0]    stg_iter;
   logic [4:0]         stv_cnt;
   logic [STAGES:1]    vld_pipe;
   meta_t [STAGES:1]   meta_pipe;

   always_comb begin
      vld_all = &twd_intt_final_vld;
      vld_any = |twd_intt_final_vld;
      // Reset gating keeps ready and accept quiet while s_rst_n is low.
      twd_ok  = vld_all & s_rst_n;
      acc     = in_vld & twd_ok;
      last_id = (intt_cnt == ID_MAX);
      err_nxt = (vld_any & ~vld_all) | (primed & ~vld_all) |
                (in_vld & ~vld_all & (stv_cnt == STV_MAX));
   end

   assign in_rdy             = twd_ok;
   assign twd_intt_final_rdy = {NL{acc & last_id}};
   assign out_vld            = vld_pipe[STAGES];
   assign out_stg_iter       = meta_pipe[STAGES].stg_iter;
   assign out_intt_id        = meta_pipe[STAGES].intt_id;

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         intt_cnt  <= '0;
         stg_iter  <= '0;
         vld_pipe  <= '0;
         meta_pipe <= '0;
         primed    <= 1'b0;
         stv_cnt   <= '0;
         error     <= 1'b0;
      end else begin
         if (acc) begin
            intt_cnt <= last_id ? '0 : intt_cnt + 1'b1;
            if (last_id)
               stg_iter <= (stg_iter == SI_MAX) ? '0 : stg_iter + 1'b1;
         end
         vld_pipe  <= {vld_pipe[STAGES-1:1], acc};
         meta_pipe <= {meta_pipe[STAGES-1:1], meta_t'{stg_iter: stg_iter, intt_id: intt_cnt}};
         primed    <= primed | vld_all;
         if (in_vld & ~vld_all)
            stv_cnt <= (stv_cnt == STV_MAX) ? STV_MAX : stv_cnt + 5'd1;
         else
            stv_cnt <= '0;
         error     <= error | err_nxt;
      end
   end

   for (genvar p = 0; p < PSI; p++) begin : g_psi
      for (genvar r = 0; r < R; r++) begin : g_r
         ntt_core_intt_final_twd_mult_lane #(
            .OP_W    (OP_W),
            .MOD_NTT (MOD_NTT)
         ) u_lane (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .a       (in_data[p][r]),
            .b       (twd_intt_final[p][r]),
            .z       (out_data[p][r])
         );
      end
   end
endmodule
